// File: rtl/f_mult_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// f_mult_rr_arbiter_pkg
// Shared float-format constants for the discriminant datapath and the small
// index helper used by the round-robin arbiter and its owner-tag FIFO.
//   FLEN : floating-point word width (IEEE-754 binary64)
//   NE   : exponent field width
// -----------------------------------------------------------------------------
package f_mult_rr_arbiter_pkg;

   localparam int FLEN = 64;
   localparam int NE   = 11;

   // Modulo-n increment of a small index; n is the number of valid slots.
   function automatic int wrap_inc(input int v, input int n);
      int r;
      if (v >= n - 1) begin
         r = 0;
      end else begin
         r = v + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/f_mult_rr_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// arb_tag_fifo
// Synchronous FIFO holding the owner index of every operation currently inside
// the shared multiplier. Head is read combinationally (fall-through).
//   clk, rst : clock, asynchronous active-high reset
//   push/din : enqueue an owner tag
//   pop      : dequeue the head tag (ignored when empty)
//   full     : DEPTH tags held
//   empty    : no tags held
//   head     : oldest tag
// -----------------------------------------------------------------------------
module arb_tag_fifo
   import f_mult_rr_arbiter_pkg::*;
#(
   parameter int WIDTH = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full  = (count_r == CNT_W'(DEPTH));
   assign empty = (count_r == {CNT_W{1'b0}});
   assign head  = mem_r[rd_ptr_r];

   // A push while full is only taken together with a pop (slot being vacated).
   assign push_ok_s = push & (~full | pop);
   assign pop_ok_s  = pop & ~empty;

   // Storage, pointers and occupancy count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= PTR_W'(wrap_inc(int'(wr_ptr_r), DEPTH));
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         if (pop_ok_s) begin
            rd_ptr_r <= PTR_W'(wrap_inc(int'(rd_ptr_r), DEPTH));
         end else begin
            rd_ptr_r <= rd_ptr_r;
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1'b1);
            2'b01:   count_r <= count_r - CNT_W'(1'b1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/f_mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// f_mult_rr_arbiter
// Shares one in-order, multi-cycle floating-point multiplier between N_REQ
// requesters. Grants round-robin (at most one issue per cycle, zero added
// latency), remembers the owner of each in-flight product and steers every
// returning result to its owner as a one-hot valid.
//   clk, rst       : clock, asynchronous active-high reset (shared with multiplier)
//   req_vld/a/b    : per-requester operand valid and packed operands
//   req_rdy        : one-hot grant (transfer on req_vld & req_rdy)
//   rsp_vld        : one-hot result valid for the owner
//   rsp_res/err    : result and error flag, broadcast
//   busy           : at least one operation in flight
//   protocol_err   : sticky, a result arrived with nothing outstanding
//   mul_*          : interface to the shared multiplier
// -----------------------------------------------------------------------------
module f_mult_rr_arbiter
   import f_mult_rr_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int FLEN         = f_mult_rr_arbiter_pkg::FLEN,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_vld,
   input  logic [N_REQ*FLEN-1:0] req_a,
   input  logic [N_REQ*FLEN-1:0] req_b,
   output logic [N_REQ-1:0]      req_rdy,
   output logic [N_REQ-1:0]      rsp_vld,
   output logic [FLEN-1:0]       rsp_res,
   output logic                  rsp_err,
   output logic                  busy,
   output logic                  protocol_err,
   output logic                  mul_arg_vld,
   output logic [FLEN-1:0]       mul_a,
   output logic [FLEN-1:0]       mul_b,
   input  logic                  mul_busy,
   input  logic                  mul_res_vld,
   input  logic [FLEN-1:0]       mul_res,
   input  logic                  mul_err
);

   localparam int TAG_W = $clog2(N_REQ);

   logic [TAG_W-1:0] ptr_r;
   logic [TAG_W-1:0] winner_s;
   logic [TAG_W-1:0] idx_s;
   logic [TAG_W-1:0] head_s;
   logic             found_s;
   logic             can_issue_s;
   logic             issue_s;
   logic             fifo_full_s;
   logic             fifo_empty_s;
   logic             pop_s;
   logic             spurious_s;
   logic             protocol_err_r;

   // Round-robin search: first valid requester at or after ptr_r, wrapping.
   always_comb begin
      winner_s = {TAG_W{1'b0}};
      found_s  = 1'b0;
      idx_s    = {TAG_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         idx_s = TAG_W'((int'(ptr_r) + k) % N_REQ);
         if (!found_s && req_vld[idx_s]) begin
            found_s  = 1'b1;
            winner_s = idx_s;
         end else begin
            found_s  = found_s;
            winner_s = winner_s;
         end
      end
   end

   // The full check uses the registered count, so a slot freed by a pop this
   // cycle becomes usable only on the next cycle.
   assign can_issue_s = ~mul_busy & ~fifo_full_s & ~rst;
   assign issue_s     = can_issue_s & found_s;

   // One-hot grant towards the winning requester.
   always_comb begin
      req_rdy = {N_REQ{1'b0}};
      if (issue_s) begin
         req_rdy = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
      end else begin
         req_rdy = {N_REQ{1'b0}};
      end
   end

   assign mul_arg_vld = |(req_vld & req_rdy);
   assign mul_a       = req_a[int'(winner_s)*FLEN +: FLEN];
   assign mul_b       = req_b[int'(winner_s)*FLEN +: FLEN];

   // A result with no recorded owner is dropped and flagged.
   assign pop_s      = mul_res_vld & ~fifo_empty_s;
   assign spurious_s = mul_res_vld &  fifo_empty_s;

   // One-hot response valid towards the owner of the oldest in-flight product.
   always_comb begin
      rsp_vld = {N_REQ{1'b0}};
      if (pop_s) begin
         rsp_vld = {{(N_REQ-1){1'b0}}, 1'b1} << head_s;
      end else begin
         rsp_vld = {N_REQ{1'b0}};
      end
   end

   assign rsp_res      = mul_res;
   assign rsp_err      = mul_err;
   assign busy         = ~fifo_empty_s;
   assign protocol_err = protocol_err_r;

   // Round-robin pointer: the requester after the last winner gets first look.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_r <= {TAG_W{1'b0}};
      end else if (issue_s) begin
         ptr_r <= TAG_W'(wrap_inc(int'(winner_s), N_REQ));
      end else begin
         ptr_r <= ptr_r;
      end
   end

   // Sticky protocol error, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         protocol_err_r <= 1'b0;
      end else if (spurious_s) begin
         protocol_err_r <= 1'b1;
      end else begin
         protocol_err_r <= protocol_err_r;
      end
   end

   arb_tag_fifo #(
      .WIDTH (TAG_W),
      .DEPTH (MAX_INFLIGHT)
   ) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (issue_s),
      .din   (winner_s),
      .pop   (pop_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .head  (head_s)
   );

endmodule
